// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch timing datapath.
// Holds the FSM state encoding, the BCD digit type and the per-digit rollover limits.
package stopwatch_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   localparam bcd_t SEC_ONES_MAX = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t MIN_ONES_MAX = 4'd9;
   localparam bcd_t MIN_TENS_MAX = 4'd5;

   // One BCD digit step that wraps back to zero once the digit's own limit is reached.
   function automatic bcd_t bcd_next(input bcd_t d, input bcd_t max);
      return (d == max) ? bcd_t'(0) : d + bcd_t'(1);
   endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Control pulses in and MM:SS digits / status out for the stopwatch counter.
// The master side is the button logic; the slave side is the counter.
interface stopwatch_bcd_counter_if;
   import stopwatch_pkg::*;

   logic ss_pulse;
   logic clr_pulse;
   logic lap_pulse;
   bcd_t d0;
   bcd_t d1;
   bcd_t d2;
   bcd_t d3;
   logic lap;
   logic running;
   logic wrap;

   modport master (
      output ss_pulse, clr_pulse, lap_pulse,
      input  d0, d1, d2, d3, lap, running, wrap
   );

   modport slave (
      input  ss_pulse, clr_pulse, lap_pulse,
      output d0, d1, d2, d3, lap, running, wrap
   );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a single-cycle tick every TICK_DIV enabled cycles.
// The count holds while disabled so a paused second resumes where it left off.
module tick_prescaler #(
   parameter int TICK_DIV = 40000000,
   parameter int DIV_W    = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   logic [DIV_W-1:0] count_q;

   assign tick = en && (count_q == DIV_W'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= tick ? '0 : count_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS stopwatch core: start/stop/clear FSM, cascaded BCD time digits and lap hold level.
// Every output is a register so the lap/freeze stage sees glitch-free levels.
module stopwatch_bcd_counter
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 40000000,
   parameter int DIV_W    = 26
) (
   input  logic                   clk,
   input  logic                   rst_n,
   stopwatch_bcd_counter_if.slave bus
);

   sw_state_t state_q;
   bcd_t      d0_q, d1_q, d2_q, d3_q;
   logic      lap_q, running_q, wrap_q;
   logic      tick;

   bcd_t d0_n, d1_n, d2_n, d3_n;
   logic c0, c1, c2, rollover;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV),
      .DIV_W    (DIV_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_q == RUN),
      .clr   (state_q == IDLE),
      .tick  (tick)
   );

   // Ripple-carry across the four digits; rollover marks 59:59 about to become 00:00.
   always_comb begin
      c0       = (d0_q == SEC_ONES_MAX);
      c1       = c0 && (d1_q == SEC_TENS_MAX);
      c2       = c1 && (d2_q == MIN_ONES_MAX);
      rollover = c2 && (d3_q == MIN_TENS_MAX);
      d0_n     = bcd_next(d0_q, SEC_ONES_MAX);
      d1_n     = c0 ? bcd_next(d1_q, SEC_TENS_MAX) : d1_q;
      d2_n     = c1 ? bcd_next(d2_q, MIN_ONES_MAX) : d2_q;
      d3_n     = c2 ? bcd_next(d3_q, MIN_TENS_MAX) : d3_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         d0_q      <= '0;
         d1_q      <= '0;
         d2_q      <= '0;
         d3_q      <= '0;
         lap_q     <= 1'b0;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!bus.clr_pulse && bus.ss_pulse) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            // Clear is deliberately ignored here; a tick and a stop in the same cycle both apply.
            RUN: begin
               if (tick) begin
                  d0_q   <= d0_n;
                  d1_q   <= d1_n;
                  d2_q   <= d2_n;
                  d3_q   <= d3_n;
                  wrap_q <= rollover;
               end
               if (bus.lap_pulse) begin
                  lap_q <= !lap_q;
               end
               if (bus.ss_pulse) begin
                  state_q   <= PAUSE;
                  running_q <= 1'b0;
               end
            end
            PAUSE: begin
               if (bus.clr_pulse) begin
                  state_q <= IDLE;
                  d0_q    <= '0;
                  d1_q    <= '0;
                  d2_q    <= '0;
                  d3_q    <= '0;
                  lap_q   <= 1'b0;
               end else begin
                  if (bus.ss_pulse) begin
                     state_q   <= RUN;
                     running_q <= 1'b1;
                  end
                  if (bus.lap_pulse) begin
                     lap_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.d0      = d0_q;
   assign bus.d1      = d1_q;
   assign bus.d2      = d2_q;
   assign bus.d3      = d3_q;
   assign bus.lap     = lap_q;
   assign bus.running = running_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench: a seconds-count model checked every cycle plus directed literal checks.
// Uses TICK_DIV=4 so a full 59:59 rollover fits in a short run.
module tb_stopwatch_bcd_counter;

   localparam int TB_DIV = 4;

   logic clk;
   logic rst_n;
   int   nCompared;
   int   nMismatched;

   stopwatch_bcd_counter_if sw_if ();

   stopwatch_bcd_counter #(
      .TICK_DIV (TB_DIV),
      .DIV_W    (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sw_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: 0 idle, 1 run, 2 pause; time as elapsed seconds, phase as cycles into the second.
   int   mState;
   int   mSecs;
   int   mPhase;
   bit   mLap;
   bit   mWrap;

   function automatic logic [18:0] modelWord();
      int mm;
      int ss;
      mm = mSecs / 60;
      ss = mSecs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), mLap, (mState == 1), mWrap};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkTime(input string name, input int mm, input int ss);
      checkOutput(name, {16'd0, sw_if.d3, sw_if.d2, sw_if.d1, sw_if.d0},
                  {16'd0, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)});
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mState = 0;
         mSecs  = 0;
         mPhase = 0;
         mLap   = 1'b0;
         mWrap  = 1'b0;
      end else begin
         mWrap = 1'b0;
         case (mState)
            0: begin
               mPhase = 0;
               if (!sw_if.clr_pulse && sw_if.ss_pulse) mState = 1;
            end
            1: begin
               if (mPhase == TB_DIV - 1) begin
                  mPhase = 0;
                  mWrap  = (mSecs == 3599);
                  mSecs  = (mSecs + 1) % 3600;
               end else begin
                  mPhase = mPhase + 1;
               end
               if (sw_if.lap_pulse) mLap = !mLap;
               if (sw_if.ss_pulse) mState = 2;
            end
            default: begin
               if (sw_if.clr_pulse) begin
                  mState = 0;
                  mSecs  = 0;
                  mPhase = 0;
                  mLap   = 1'b0;
               end else begin
                  if (sw_if.ss_pulse) mState = 1;
                  if (sw_if.lap_pulse) mLap = 1'b0;
               end
            end
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         checkOutput("model", {13'd0, sw_if.d3, sw_if.d2, sw_if.d1, sw_if.d0, sw_if.lap, sw_if.running,
                               sw_if.wrap}, {13'd0, modelWord()});
      end
   end

   // Drives one pulse cycle; entered and left positioned just after a falling edge.
   task automatic applyStimulus(input bit ss, input bit clr, input bit lp);
      sw_if.ss_pulse  = ss;
      sw_if.clr_pulse = clr;
      sw_if.lap_pulse = lp;
      @(negedge clk);
      sw_if.ss_pulse  = 1'b0;
      sw_if.clr_pulse = 1'b0;
      sw_if.lap_pulse = 1'b0;
   endtask

   task automatic runCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      nCompared       = 0;
      nMismatched     = 0;
      rst_n           = 1'b0;
      sw_if.ss_pulse  = 1'b0;
      sw_if.clr_pulse = 1'b0;
      sw_if.lap_pulse = 1'b0;

      #12;
      checkTime("reset_digits", 0, 0);
      checkOutput("reset_flags", {29'd0, sw_if.lap, sw_if.running, sw_if.wrap}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] start and first ticks");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("start_running", {31'd0, sw_if.running}, 32'd1);
      runCycles(4);
      checkTime("first_tick", 0, 1);
      runCycles(8);
      checkTime("after_12", 0, 3);

      $display("[TB] carries");
      runCycles(4 * 6);
      checkTime("at_00_09", 0, 9);
      runCycles(4);
      checkTime("at_00_10", 0, 10);
      runCycles(4 * 49);
      checkTime("at_00_59", 0, 59);
      runCycles(4);
      checkTime("at_01_00", 1, 0);
      runCycles(4 * 539);
      checkTime("at_09_59", 9, 59);
      runCycles(4);
      checkTime("at_10_00", 10, 0);
      runCycles(4 * 2999);
      checkTime("at_59_59", 59, 59);
      checkOutput("pre_wrap", {31'd0, sw_if.wrap}, 32'd0);
      runCycles(4);
      checkTime("rollover", 0, 0);
      checkOutput("wrap_pulse", {31'd0, sw_if.wrap}, 32'd1);
      checkOutput("wrap_running", {31'd0, sw_if.running}, 32'd1);
      runCycles(1);
      checkOutput("wrap_one_cycle", {31'd0, sw_if.wrap}, 32'd0);

      $display("[TB] pause and resume");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("paused", {31'd0, sw_if.running}, 32'd0);
      runCycles(10);
      checkTime("pause_hold", 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("resumed", {31'd0, sw_if.running}, 32'd1);
      runCycles(1);
      checkTime("resume_1", 0, 0);
      runCycles(1);
      checkTime("resume_2", 0, 1);

      $display("[TB] clear handling");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("clr_in_run", {31'd0, sw_if.running}, 32'd1);
      checkTime("clr_in_run_time", 0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("lap_before_clr", {31'd0, sw_if.lap}, 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkTime("clr_time", 0, 0);
      checkOutput("clr_flags", {29'd0, sw_if.lap, sw_if.running, sw_if.wrap}, 32'd0);
      runCycles(3);
      checkOutput("idle_stays", {31'd0, sw_if.running}, 32'd0);

      $display("[TB] lap handling");
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lap_set", {31'd0, sw_if.lap}, 32'd1);
      runCycles(3);
      checkTime("lap_counting", 0, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lap_toggle_off", {31'd0, sw_if.lap}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("lap_in_pause", {31'd0, sw_if.lap}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lap_cleared_pause", {31'd0, sw_if.lap}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lap_stays_pause", {31'd0, sw_if.lap}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(9);

      $display("[TB] asynchronous reset");
      #2;
      rst_n = 1'b0;
      #1;
      checkTime("async_digits", 0, 0);
      checkOutput("async_flags", {29'd0, sw_if.lap, sw_if.running, sw_if.wrap}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lap_in_idle", {30'd0, sw_if.lap, sw_if.running}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(3);
      checkTime("restart_3", 0, 0);
      runCycles(1);
      checkTime("restart_4", 0, 1);
      runCycles(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
Upstream timing stage of the stopwatch datapath. Holds the MM:SS time as four BCD digits and advances it on a prescaled 1 Hz tick. Start/stop, clear and lap control come from single-cycle button pulses. Drives d0..d3 and a lap hold level directly into the lap/freeze stage, which displays the digits.

Parameters:
TICK_DIV, 40000000, clk cycles per count tick (1 s at 40 MHz); must be >= 2
DIV_W, 26, prescaler counter width; must satisfy 2**DIV_W >= TICK_DIV

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ss_pulse  input  1  start/stop request, one-cycle pulse from debouncer
clr_pulse  input  1  clear request, one-cycle pulse
lap_pulse  input  1  lap toggle request, one-cycle pulse
d0  output  4  seconds ones, BCD 0-9
d1  output  4  seconds tens, BCD 0-5
d2  output  4  minutes ones, BCD 0-9
d3  output  4  minutes tens, BCD 0-5
lap  output  1  freeze request level to the lap stage
running  output  1  high while in RUN
wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover

Behaviour:
- Reset (async): state=IDLE, d0..d3=0, lap=0, running=0, wrap=0, prescaler=0.
- States: IDLE (zeroed, stopped), RUN, PAUSE. All outputs are registered. running = (state==RUN).
- Transitions on ss_pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. The state change is visible the cycle after the pulse.
- clr_pulse in IDLE or PAUSE: go to IDLE next cycle, clear digits, lap, and prescaler.
- clr_pulse in RUN: ignored, no effect.
- clr_pulse and ss_pulse in the same cycle: clr wins if legal. In RUN, clr is ignored and ss applies.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUN.
  - Holds its value in PAUSE, so a resume continues the partial second.
  - Zeroed in IDLE.
- tick: internal, asserted in the RUN cycle where prescaler==TICK_DIV-1; the prescaler returns to 0 on that cycle.
- First tick occurs TICK_DIV cycles after entering RUN from IDLE. Digits update on the clock edge ending the tick cycle.
- A tick coinciding with ss_pulse in RUN is still applied. The state enters PAUSE with the incremented time.
- BCD increment, cascaded:
  - d0 0..9; at 9, d0 wraps to 0 and carries into d1.
  - d1 0..5, carries into d2.
  - d2 0..9, carries into d3.
  - d3 0..5.
  - 59:59 + tick -> 00:00, and wrap=1 for exactly that cycle; the stopwatch stays in RUN.
- Digits never leave their legal BCD ranges. There is no saturation.
- Lap:
  - lap_pulse in RUN toggles lap.
  - lap_pulse in PAUSE with lap=1 clears lap. lap_pulse in PAUSE with lap=0 has no effect.
  - lap_pulse in IDLE: no effect.
  - The counter keeps running regardless of lap; only the downstream stage freezes.
- Events evaluated against the current state; each input pulse is consumed once. Held-high pulse inputs are treated as one pulse per cycle (caller's responsibility).
- Reset mid-count: immediate return to the reset values, independent of clk.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2)
  - digit limits (SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, MIN_TENS_MAX=5)
  - the BCD digit width (4)
- One sub-module, tick_prescaler, with ports clk, rst_n, en (RUN), clr (IDLE), tick. It holds the count when en=0 and clr=0.
- The FSM, BCD cascade and lap logic stay in the top module.

Test Plan:
1. Reset with TICK_DIV=4, then assert ss_pulse for 1 cycle -> running=1 next cycle; d0=1 after 4 RUN cycles; d0=3 after 12 cycles.
2. Preload via 9 ticks, then 1 more tick -> d0=0, d1=1. Run to 00:59, then 1 tick -> 01:00. Run to 09:59 -> 10:00.
3. Run to 59:59, then tick -> d3..d0=0, wrap=1 for exactly one cycle, running stays 1.
4. ss_pulse at prescaler=2, wait 10 cycles, then ss_pulse again -> digits unchanged during PAUSE; the next increment comes 2 RUN cycles after resume.
5. In RUN, assert clr_pulse -> ignored. In PAUSE, assert clr_pulse together with ss_pulse -> IDLE, digits 0, lap 0, running 0.
6. In RUN, lap_pulse -> lap=1 while digits keep counting; second lap_pulse -> lap=0. Then lap=1, ss_pulse, lap_pulse in PAUSE -> lap=0. Async rst_n drop mid-run -> all outputs 0 without a clk edge.
